// File: rtl/fme_half_sched_pkg.sv
// Shared definitions for the FME half-pel sequencer: candidate indices,
// FSM states, the per-candidate tap offset table and small helpers.
package fme_pkg;

  localparam int MB_DIM = 16;
  localparam int N_TAPS = 6;

  localparam logic [1:0] CAND_UP = 2'd0;
  localparam logic [1:0] CAND_DN = 2'd1;
  localparam logic [1:0] CAND_LT = 2'd2;
  localparam logic [1:0] CAND_RT = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_FETCH,
    ST_LAND,
    ST_FILT,
    ST_WAIT,
    ST_OUT,
    ST_DONE
  } state_t;

  typedef logic signed [2:0] off_t;

  // Spatial offsets t0..t5 along the candidate's axis. Up/left straddle the
  // half-pel position before the centre, down/right the one after it.
  localparam off_t TAP_OFF [4][N_TAPS] = '{
    '{-3'sd3, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2},  // up
    '{-3'sd2, -3'sd1,  3'sd0, 3'sd1, 3'sd2, 3'sd3},  // down
    '{-3'sd3, -3'sd2, -3'sd1, 3'sd0, 3'sd1, 3'sd2},  // left
    '{-3'sd2, -3'sd1,  3'sd0, 3'sd1, 3'sd2, 3'sd3}   // right
  };

  // Edge padding: coordinates outside the macroblock stick to the border.
  function automatic logic [3:0] clamp_coord(input logic signed [5:0] v);
    if (v < 0)                return 4'd0;
    else if (v > MB_DIM - 1)  return 4'(MB_DIM - 1);
    else                      return v[3:0];
  endfunction

  // Candidates are serviced lowest mask bit first.
  function automatic logic [1:0] lowest_cand(input logic [3:0] m);
    if (m[0])      return CAND_UP;
    else if (m[1]) return CAND_DN;
    else if (m[2]) return CAND_LT;
    else           return CAND_RT;
  endfunction

endpackage

// File: rtl/fme_half_sched_if.sv
// Bundle of the sequencer's control, RAM, filter and result signals.
// slave = the sequencer itself, master = its environment.
// Optional FME_HALF_BEST_EN adds the best-candidate tracking signals.
interface fme_half_sched_if;
  logic        start;
  logic [7:0]  centre_idx;
  logic [3:0]  cand_mask;
  logic        busy;
  logic        ram_rd_en;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_rd_data;
  logic        filt_valid;
  logic [47:0] filt_taps;
  logic [7:0]  filt_half;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_cand;
  logic [7:0]  res_pix;
  logic        done;
`ifdef FME_HALF_BEST_EN
  logic [7:0]  cur_pix;
  logic [1:0]  best_cand;
  logic [7:0]  best_diff;

  modport slave (
    input  start, centre_idx, cand_mask, ram_rd_data, filt_half, res_ready, cur_pix,
    output busy, ram_rd_en, ram_addr, filt_valid, filt_taps,
           res_valid, res_cand, res_pix, done, best_cand, best_diff
  );
  modport master (
    output start, centre_idx, cand_mask, ram_rd_data, filt_half, res_ready, cur_pix,
    input  busy, ram_rd_en, ram_addr, filt_valid, filt_taps,
           res_valid, res_cand, res_pix, done, best_cand, best_diff
  );
`else
  modport slave (
    input  start, centre_idx, cand_mask, ram_rd_data, filt_half, res_ready,
    output busy, ram_rd_en, ram_addr, filt_valid, filt_taps,
           res_valid, res_cand, res_pix, done
  );
  modport master (
    output start, centre_idx, cand_mask, ram_rd_data, filt_half, res_ready,
    input  busy, ram_rd_en, ram_addr, filt_valid, filt_taps,
           res_valid, res_cand, res_pix, done
  );
`endif
endinterface

// File: rtl/fme_half_sched_tap_addr.sv
// Combinational tap address generator: centre pixel, candidate and tap
// index to a border-clamped reference RAM address {row,col}.
module fme_tap_addr
  import fme_pkg::*;
(
  input  logic [7:0] i_centre_idx,
  input  logic [1:0] i_cand,
  input  logic [2:0] i_k,
  output logic [7:0] o_addr
);

  off_t              w_off;
  logic              w_vert;
  logic signed [5:0] w_row;
  logic signed [5:0] w_col;

  // Offset the centre along the candidate's axis, then clamp both coordinates.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block
    // can leave a value unassigned and infer a latch.
    w_off  = (i_k < 3'(N_TAPS)) ? TAP_OFF[i_cand][i_k] : '0;
    w_vert = (i_cand == CAND_UP) || (i_cand == CAND_DN);
    w_row  = $signed({2'b00, i_centre_idx[7:4]});
    w_col  = $signed({2'b00, i_centre_idx[3:0]});
    if (w_vert) w_row = w_row + $signed({{3{w_off[2]}}, w_off});
    else        w_col = w_col + $signed({{3{w_off[2]}}, w_off});
    o_addr = {clamp_coord(w_row), clamp_coord(w_col)};
  end

endmodule

// File: rtl/fme_half_sched.sv
// FME half-pel sequencer: for each selected candidate fetches six integer
// taps (one RAM read per cycle), presents them to the external six-tap
// filter and returns one half-pel sample over a valid/ready stream.
// Optional feature: define FME_HALF_BEST_EN for best-candidate tracking.
module fme_half_sched
  import fme_pkg::*;
#(
  parameter int FILT_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  fme_half_sched_if.slave io_sched
);

  localparam int WCW = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;

  state_t          r_state;
  state_t          w_next;
  logic [7:0]      r_centre;
  logic [3:0]      r_pending;
  logic [1:0]      r_cand;
  logic [2:0]      r_k;
  logic [7:0]      r_win [5];
  logic [47:0]     r_filt_taps;
  logic [WCW-1:0]  r_wait_cnt;
  logic [7:0]      r_res_pix;
  logic [7:0]      w_tap_addr;
  logic            w_handshake;

  fme_tap_addr u_tap_addr (
    .i_centre_idx (r_centre),
    .i_cand       (r_cand),
    .i_k          (r_k),
    .o_addr       (w_tap_addr)
  );

  assign w_handshake = (r_state == ST_OUT) && io_sched.res_ready;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic. The first candidate is chosen at accept, so a
  // non-empty job goes straight to FETCH; SEL is entered from IDLE only for
  // an empty mask, and otherwise after each result handshake.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (io_sched.start)
                  w_next = (io_sched.cand_mask != 4'd0) ? ST_FETCH : ST_SEL;
      ST_SEL:   w_next = (r_pending != 4'd0) ? ST_FETCH : ST_DONE;
      ST_FETCH: if (r_k == 3'(N_TAPS - 1)) w_next = ST_LAND;
      ST_LAND:  w_next = ST_FILT;
      ST_FILT:  w_next = ST_WAIT;
      ST_WAIT:  if (r_wait_cnt == '0) w_next = ST_OUT;
      ST_OUT:   if (io_sched.res_ready) w_next = ST_SEL;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Job latch, candidate selection, tap counter, tap window, filter wait
  // and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_centre    <= '0;
      r_pending   <= '0;
      r_cand      <= '0;
      r_k         <= '0;
      r_filt_taps <= '0;
      r_wait_cnt  <= '0;
      r_res_pix   <= '0;
      // NOTE: the tap window is five flops, not a RAM, so it is cleared with
      // the rest of the state.
      for (int i = 0; i < 5; i++) r_win[i] <= '0;
    end else begin
      // Read data for tap k lands one cycle after its read; tap 5 lands in
      // LAND and goes straight into the presented window.
      if (r_state == ST_FETCH && r_k != 3'd0) r_win[r_k - 3'd1] <= io_sched.ram_rd_data;

      unique case (r_state)
        ST_IDLE: if (io_sched.start) begin
          r_centre  <= io_sched.centre_idx;
          r_cand    <= lowest_cand(io_sched.cand_mask);
          r_pending <= io_sched.cand_mask & ~(4'b0001 << lowest_cand(io_sched.cand_mask));
          r_k       <= '0;
        end
        ST_SEL: if (r_pending != 4'd0) begin
          r_cand    <= lowest_cand(r_pending);
          r_pending <= r_pending & ~(4'b0001 << lowest_cand(r_pending));
          r_k       <= '0;
        end
        ST_FETCH: r_k <= r_k + 3'd1;
        ST_LAND:  r_filt_taps <= {io_sched.ram_rd_data, r_win[4], r_win[3],
                                  r_win[2], r_win[1], r_win[0]};
        ST_FILT:  r_wait_cnt <= WCW'(FILT_LAT - 1);
        ST_WAIT:  if (r_wait_cnt == '0) r_res_pix <= io_sched.filt_half;
                  else                  r_wait_cnt <= r_wait_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign io_sched.busy       = (r_state != ST_IDLE);
  assign io_sched.ram_rd_en  = (r_state == ST_FETCH);
  assign io_sched.ram_addr   = (r_state == ST_FETCH) ? w_tap_addr : 8'd0;
  assign io_sched.filt_valid = (r_state == ST_FILT);
  assign io_sched.filt_taps  = r_filt_taps;
  assign io_sched.res_valid  = (r_state == ST_OUT);
  assign io_sched.res_cand   = r_cand;
  assign io_sched.res_pix    = r_res_pix;
  assign io_sched.done       = (r_state == ST_DONE);

`ifdef FME_HALF_BEST_EN
  logic [7:0] r_cur_pix;
  logic [1:0] r_best_cand;
  logic [7:0] r_best_diff;
  logic [7:0] w_diff;

  assign w_diff = (r_res_pix > r_cur_pix) ? (r_res_pix - r_cur_pix) : (r_cur_pix - r_res_pix);

  // Track the candidate closest to the current pixel; a strict compare
  // keeps the earlier candidate on ties.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_pix   <= '0;
      r_best_cand <= '0;
      r_best_diff <= '0;
    end else if (r_state == ST_IDLE && io_sched.start) begin
      r_cur_pix   <= io_sched.cur_pix;
      r_best_cand <= '0;
      r_best_diff <= 8'hFF;
    end else if (w_handshake && (w_diff < r_best_diff)) begin
      r_best_cand <= r_cand;
      r_best_diff <= w_diff;
    end
  end

  assign io_sched.best_cand = r_best_cand;
  assign io_sched.best_diff = r_best_diff;
`endif

endmodule

// File: tb/tb_fme_half_sched.sv
// Directed bench for fme_half_sched with FILT_LAT=1. RAM model returns
// mem[a]=a one cycle after a read; the filter model registers tap t2.
module tb_fme_half_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   hs_cnt   = 0;
  logic [7:0] last_pix = '0;

  fme_half_sched_if bus ();

  fme_half_sched #(.FILT_LAT(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .io_sched (bus.slave)
  );

  always #5 clk = ~clk;

  // Reference RAM: data valid one cycle after the read strobe.
  always @(posedge clk) if (bus.ram_rd_en) bus.ram_rd_data <= bus.ram_addr;

  // Filter: registered centre tap t2.
  always @(posedge clk) if (bus.filt_valid) bus.filt_half <= bus.filt_taps[23:16];

  // Event counters for whole-job checks.
  always @(posedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.res_valid && bus.res_ready) begin
      hs_cnt++;
      last_pix = bus.res_pix;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns in cycle t+1.
  task automatic start_job(input logic [7:0] centre, input logic [3:0] mask);
    bus.centre_idx = centre;
    bus.cand_mask  = mask;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Entered in the cycle of the first read; returns in SEL after the handshake.
  // With mem[a]=a the expected tap window equals the packed address list.
  task automatic cand_seq(input string tag, input logic [47:0] addrs,
                          input logic [1:0] cand, input logic [7:0] pix, input int stall);
    for (int k = 0; k < 6; k++) begin
      check({tag, "_rd_en"}, 48'(bus.ram_rd_en), 48'd1);
      check({tag, "_addr"}, 48'(bus.ram_addr), 48'(addrs[8*k +: 8]));
      tick();
    end
    check({tag, "_land_rd_en"}, 48'(bus.ram_rd_en), 48'd0);
    check({tag, "_land_fv"}, 48'(bus.filt_valid), 48'd0);
    tick();
    check({tag, "_filt_valid"}, 48'(bus.filt_valid), 48'd1);
    check({tag, "_filt_taps"}, bus.filt_taps, addrs);
    tick();
    check({tag, "_wait_fv"}, 48'(bus.filt_valid), 48'd0);
    check({tag, "_wait_rv"}, 48'(bus.res_valid), 48'd0);
    check({tag, "_wait_taps_held"}, bus.filt_taps, addrs);
    tick();
    check({tag, "_res_valid"}, 48'(bus.res_valid), 48'd1);
    check({tag, "_res_cand"}, 48'(bus.res_cand), 48'(cand));
    check({tag, "_res_pix"}, 48'(bus.res_pix), 48'(pix));
    for (int s = 0; s < stall; s++) begin
      tick();
      check({tag, "_stall_valid"}, 48'(bus.res_valid), 48'd1);
      check({tag, "_stall_pix"}, 48'(bus.res_pix), 48'(pix));
      check({tag, "_stall_cand"}, 48'(bus.res_cand), 48'(cand));
    end
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_sel_rv"}, 48'(bus.res_valid), 48'd0);
    check({tag, "_sel_rd_en"}, 48'(bus.ram_rd_en), 48'd0);
  endtask

  // Called in the cycle after the last handshake (SEL).
  task automatic finish_seq(input string tag);
    check({tag, "_sel_done"}, 48'(bus.done), 48'd0);
    check({tag, "_sel_busy"}, 48'(bus.busy), 48'd1);
    tick();
    check({tag, "_done"}, 48'(bus.done), 48'd1);
    tick();
    check({tag, "_idle_done"}, 48'(bus.done), 48'd0);
    check({tag, "_idle_busy"}, 48'(bus.busy), 48'd0);
  endtask

  initial begin
    int base_done;
    int base_hs;
    int n;
    bus.start = 1'b0; bus.centre_idx = '0; bus.cand_mask = '0;
    bus.res_ready = 1'b0; bus.ram_rd_data = '0; bus.filt_half = '0;
`ifdef FME_HALF_BEST_EN
    bus.cur_pix = '0;
`endif
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy", 48'(bus.busy), 48'd0);
    check("rst_rd_en", 48'(bus.ram_rd_en), 48'd0);
    check("rst_addr", 48'(bus.ram_addr), 48'd0);
    check("rst_fv", 48'(bus.filt_valid), 48'd0);
    check("rst_taps", bus.filt_taps, 48'd0);
    check("rst_rv", 48'(bus.res_valid), 48'd0);
    check("rst_pix", 48'(bus.res_pix), 48'd0);
    check("rst_cand", 48'(bus.res_cand), 48'd0);
    check("rst_done", 48'(bus.done), 48'd0);
`ifdef FME_HALF_BEST_EN
    check("rst_best_cand", 48'(bus.best_cand), 48'd0);
    check("rst_best_diff", 48'(bus.best_diff), 48'd0);
`endif

    // 1: centre 0x55, up only
    start_job(8'h55, 4'b0001);
    check("t1_busy", 48'(bus.busy), 48'd1);
    cand_seq("t1", 48'h756555453525, 2'd0, 8'h45, 0);
    finish_seq("t1");

    // 2: centre 0x00, left only, clamped at the left/top border
    start_job(8'h00, 4'b0100);
    cand_seq("t2", 48'h020100000000, 2'd2, 8'h00, 0);
    finish_seq("t2");

    // 3: centre 0xFF, all four with 5-cycle stalls, clamped at bottom/right
    start_job(8'hFF, 4'b1111);
    cand_seq("t3_up", 48'hFFFFFFEFDFCF, 2'd0, 8'hEF, 5);
    tick();
    cand_seq("t3_dn", 48'hFFFFFFFFEFDF, 2'd1, 8'hFF, 5);
    tick();
    cand_seq("t3_lt", 48'hFFFFFFFEFDFC, 2'd2, 8'hFE, 5);
    tick();
    cand_seq("t3_rt", 48'hFFFFFFFFFEFD, 2'd3, 8'hFF, 5);
    finish_seq("t3");

    // 4: empty mask
    start_job(8'h55, 4'b0000);
    check("t4_busy", 48'(bus.busy), 48'd1);
    check("t4_rd_en1", 48'(bus.ram_rd_en), 48'd0);
    check("t4_rv1", 48'(bus.res_valid), 48'd0);
    check("t4_done1", 48'(bus.done), 48'd0);
    tick();
    check("t4_done", 48'(bus.done), 48'd1);
    check("t4_rd_en2", 48'(bus.ram_rd_en), 48'd0);
    check("t4_rv2", 48'(bus.res_valid), 48'd0);
    tick();
    check("t4_idle_busy", 48'(bus.busy), 48'd0);

    // 5a: reset during FETCH k=3
    start_job(8'h55, 4'b0001);
    tick(); tick(); tick();
    check("t5_k3_addr", 48'(bus.ram_addr), 48'h55);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", 48'(bus.busy), 48'd0);
    check("t5_rst_rd_en", 48'(bus.ram_rd_en), 48'd0);
    check("t5_rst_rv", 48'(bus.res_valid), 48'd0);

    // 5b: start while busy is ignored
    base_done = done_cnt;
    base_hs   = hs_cnt;
    bus.res_ready = 1'b1;
    start_job(8'h33, 4'b0001);
    tick(); tick();
    bus.centre_idx = 8'h00;
    bus.cand_mask  = 4'b1111;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    n = 0;
    while (!bus.done && n < 60) begin tick(); n++; end
    check("t5_done_seen", 48'(bus.done), 48'd1);
    tick(); tick(); tick(); tick();
    bus.res_ready = 1'b0;
    check("t5_one_done", 48'(done_cnt - base_done), 48'd1);
    check("t5_one_result", 48'(hs_cnt - base_hs), 48'd1);
    check("t5_result_pix", 48'(last_pix), 48'h23);
    check("t5_idle_busy", 48'(bus.busy), 48'd0);

`ifdef FME_HALF_BEST_EN
    // 6: results 45,55,54,55 against 0x56 -> diffs 11,01,02,01; tie keeps down
    bus.cur_pix   = 8'h56;
    bus.res_ready = 1'b1;
    start_job(8'h55, 4'b1111);
    n = 0;
    while (!bus.done && n < 100) begin tick(); n++; end
    check("t6_done_seen", 48'(bus.done), 48'd1);
    check("t6_best_cand", 48'(bus.best_cand), 48'd1);
    check("t6_best_diff", 48'(bus.best_diff), 48'h01);
    check("t6_last_pix", 48'(last_pix), 48'h55);
    bus.res_ready = 1'b0;
    tick();
    check("t6_best_held", 48'(bus.best_diff), 48'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
